otter_csr_intr: RTL and testbench
=================================

Name: otter_csr_intr

Overview:
Machine-mode CSR file and interrupt front end for the multicycle core. It sits between the external interrupt pin and the control-unit FSM, and feeds that FSM a gated INTR request. It consumes the FSM's csr_WE, int_taken and mret_exec strobes, and supplies the datapath with mepc, mtvec and CSR read data.

Parameters:
- SYNC_STAGES, 2, number of flops in the intr_async synchronizer (legal values 2 or 3).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- RST  input  1  reset, synchronous, active-high
- intr_async  input  1  raw external interrupt, asynchronous to clk
- int_taken  input  1  FSM strobe: interrupt is being entered this cycle
- mret_exec  input  1  FSM strobe: mret executing this cycle
- csr_WE  input  1  FSM strobe: write CSR at addr this cycle
- addr  input  12  CSR address (instruction bits 31:20)
- wd  input  32  CSR write data
- pc  input  32  return address to capture into mepc on int_taken
- rd  output  32  combinational CSR read data for addr
- mepc  output  32  current mepc register
- mtvec  output  32  current mtvec register
- mie  output  1  mstatus.MIE
- INTR  output  1  interrupt request to FSM = pending & mie

Behaviour:
- Reset: mstatus, mtvec, mepc and (if enabled) mcause are 0. Synchronizer flops, edge-history flop and pending flag are 0. INTR=0, mie=0, rd=0 for every address.
- CSR map:
  - mstatus 0x300: only bit 3 (MIE) and bit 7 (MPIE) are implemented; all other bits read 0, and writes to them are discarded.
  - mtvec 0x305: bits 1:0 are forced to 0 (direct mode only).
  - mepc 0x341: bits 1:0 are forced to 0.
  - Unmapped address: rd=0 and writes are ignored.
- rd is purely combinational from addr and the current register values. A write is visible on rd the cycle after csr_WE.
- int_taken (one cycle): mepc<=pc with bits 1:0 cleared, MPIE<=MIE, MIE<=0.
- mret_exec (one cycle): MIE<=MPIE, MPIE<=1.
- csr_WE: the addressed register <= wd, after masking.
- Same-cycle strobe priority: int_taken > mret_exec > csr_WE. Only the winning update is applied; lower-priority updates are dropped for the whole cycle, not just for shared fields.
- Interrupt front end:
  - intr_async passes through a SYNC_STAGES flop chain; s is the last stage and p is s delayed by one flop.
  - Rising edge: edge = s & ~p.
  - Pending FSM has states IDLE (pending=0) and PEND (pending=1):
    - IDLE -> PEND on edge.
    - PEND -> IDLE on int_taken without edge.
    - PEND stays PEND on int_taken with edge (set wins, so back-to-back events are not lost).
    - An edge while already PEND is merged (one request).
    - int_taken while IDLE has no effect on pending.
- Latency (SYNC_STAGES=2): intr_async high and stable from before edge k gives pending=1 after edge k+2, and INTR=1 in the same cycle if mie=1. A level held high produces one request only; a new request needs a low period of at least SYNC_STAGES+1 cycles.
- INTR is masked, never cleared, by mie=0. A request pending while MIE=0 asserts INTR once software sets MIE.
- RST mid-operation clears everything above on the next edge, including a pending request.

Optional Feature:
- Macro CSR_MCAUSE_EN.
- Defined: mcause at 0x342, 32-bit, fully read/write via csr_WE. On int_taken it loads 0x8000000B (machine external interrupt), following the same priority rules.
- Undefined: no register is implemented; 0x342 reads 0 and writes are ignored.

Decomposition:
- Package otter_csr_pkg holds:
  - CSR address localparams: ADDR_MSTATUS, ADDR_MTVEC, ADDR_MEPC, ADDR_MCAUSE.
  - mstatus bit indices: MIE_BIT=3, MPIE_BIT=7.
  - MCAUSE_MEXT=32'h8000000B.
- Sub-module otter_intr_sync holds the synchronizer, edge detect and pending FSM. Its inputs are clk, RST, intr_async and int_taken; its output is pending.

Test Plan:
- Reset -> rd=0 at 0x300/0x305/0x341, INTR=0, mepc=0, mtvec=0.
- csr_WE addr=0x305 wd=0x00001003 -> mtvec=0x00001000 next cycle. Then addr=0x300 wd=0xFFFFFFFF -> rd=0x00000088, mie=1.
- MIE=1, intr_async 0->1 before edge k -> INTR=1 after edge k+2. int_taken with pc=0x00000104 -> mepc=0x104, mstatus reads 0x80, INTR=0 next cycle.
- mret_exec after the previous scenario -> mstatus reads 0x88. Same cycle mret_exec + csr_WE to mstatus wd=0 -> mstatus reads 0x88 (write dropped).
- MIE=0, one intr edge -> INTR stays 0. csr_WE mstatus=0x8 -> INTR=1 next cycle. Edge coincident with int_taken -> pending remains 1.
- With CSR_MCAUSE_EN: int_taken -> rd@0x342=0x8000000B. Without it -> rd@0x342=0 after csr_WE wd=0x1234.

Source files
------------

// File: rtl/otter_csr_pkg.sv
// Shared constants and types for the OTTER machine-mode CSR file and
// interrupt front end.
package otter_csr_pkg;

   // CSR addresses (instruction bits 31:20)
   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

   // mstatus implemented bit positions
   localparam int unsigned MIE_BIT  = 3;
   localparam int unsigned MPIE_BIT = 7;

   // mcause value for a machine external interrupt
   localparam logic [31:0] MCAUSE_MEXT = 32'h8000_000B;

   // mtvec/mepc are word aligned: bits 1:0 always read 0
   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   // Pending-request state
   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } pend_state_t;

endpackage

// File: rtl/otter_intr_sync.sv
// External interrupt synchronizer, rising-edge detector and pending-request
// FSM. One request is held per rising edge of the synchronized input until
// the control unit takes it.
module otter_intr_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic RST,
   input  logic intr_async,
   input  logic int_taken,
   output logic pending
);
   import otter_csr_pkg::*;

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   logic                   p;
   logic                   edge_det;
   pend_state_t            state;

   assign s        = sync[SYNC_STAGES-1];
   assign edge_det = s & ~p;

   // Synchronizer chain plus one-flop edge history
   always_ff @(posedge clk) begin
      if (RST) begin
         sync <= '0;
         p    <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], intr_async};
         p    <= s;
      end
   end

   // Pending FSM: a new edge wins over int_taken so back-to-back events survive
   always_ff @(posedge clk) begin
      if (RST) begin
         state   <= IDLE;
         pending <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (edge_det) begin
                  state   <= PEND;
                  pending <= 1'b1;
               end
            end
            PEND: begin
               if (int_taken && !edge_det) begin
                  state   <= IDLE;
                  pending <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               pending <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/otter_csr_intr.sv
// Machine-mode CSR file (mstatus, mtvec, mepc, optional mcause) and the
// gated interrupt request to the control-unit FSM.
// Optional feature macro: CSR_MCAUSE_EN (implements mcause at 0x342).
module otter_csr_intr #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        RST,
   input  logic        intr_async,
   input  logic        int_taken,
   input  logic        mret_exec,
   input  logic        csr_WE,
   input  logic [11:0] addr,
   input  logic [31:0] wd,
   input  logic [31:0] pc,
   output logic [31:0] rd,
   output logic [31:0] mepc,
   output logic [31:0] mtvec,
   output logic        mie,
   output logic        INTR
);
   import otter_csr_pkg::*;

   logic        mie_r;
   logic        mpie_r;
   logic [31:0] mtvec_r;
   logic [31:0] mepc_r;
   logic [31:0] mstatus_val;
   logic        pending;
`ifdef CSR_MCAUSE_EN
   logic [31:0] mcause_r;
`endif

   otter_intr_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .RST       (RST),
      .intr_async(intr_async),
      .int_taken (int_taken),
      .pending   (pending)
   );

   assign mepc  = mepc_r;
   assign mtvec = mtvec_r;
   assign mie   = mie_r;
   assign INTR  = pending & mie_r;

   // CSR updates; strobe priority int_taken > mret_exec > csr_WE, loser dropped whole
   always_ff @(posedge clk) begin
      if (RST) begin
         mie_r    <= 1'b0;
         mpie_r   <= 1'b0;
         mtvec_r  <= '0;
         mepc_r   <= '0;
`ifdef CSR_MCAUSE_EN
         mcause_r <= '0;
`endif
      end else if (int_taken) begin
         mepc_r   <= pc & ALIGN_MASK;
         mpie_r   <= mie_r;
         mie_r    <= 1'b0;
`ifdef CSR_MCAUSE_EN
         mcause_r <= MCAUSE_MEXT;
`endif
      end else if (mret_exec) begin
         mie_r  <= mpie_r;
         mpie_r <= 1'b1;
      end else if (csr_WE) begin
         case (addr)
            ADDR_MSTATUS: begin
               mie_r  <= wd[MIE_BIT];
               mpie_r <= wd[MPIE_BIT];
            end
            ADDR_MTVEC:  mtvec_r  <= wd & ALIGN_MASK;
            ADDR_MEPC:   mepc_r   <= wd & ALIGN_MASK;
`ifdef CSR_MCAUSE_EN
            ADDR_MCAUSE: mcause_r <= wd;
`endif
            default: ;
         endcase
      end
   end

   // mstatus view: only MIE and MPIE are implemented
   always_comb begin
      mstatus_val           = '0;
      mstatus_val[MIE_BIT]  = mie_r;
      mstatus_val[MPIE_BIT] = mpie_r;
   end

   // Combinational CSR read mux; unmapped addresses read 0
   always_comb begin
      rd = '0;
      case (addr)
         ADDR_MSTATUS: rd = mstatus_val;
         ADDR_MTVEC:   rd = mtvec_r;
         ADDR_MEPC:    rd = mepc_r;
`ifdef CSR_MCAUSE_EN
         ADDR_MCAUSE:  rd = mcause_r;
`endif
         default:      rd = '0;
      endcase
   end

endmodule

// File: tb/tb_otter_csr_intr.sv
// Directed self-checking bench for otter_csr_intr (SYNC_STAGES=2).
module tb_otter_csr_intr;

   logic        clk = 1'b0;
   logic        RST = 1'b1;
   logic        intr_async = 1'b0;
   logic        int_taken = 1'b0;
   logic        mret_exec = 1'b0;
   logic        csr_WE = 1'b0;
   logic [11:0] addr = 12'h000;
   logic [31:0] wd = '0;
   logic [31:0] pc = '0;
   logic [31:0] rd;
   logic [31:0] mepc;
   logic [31:0] mtvec;
   logic        mie;
   logic        INTR;

   int checks = 0;
   int errors = 0;

   otter_csr_intr #(.SYNC_STAGES(2)) dut (
      .clk       (clk),
      .RST       (RST),
      .intr_async(intr_async),
      .int_taken (int_taken),
      .mret_exec (mret_exec),
      .csr_WE    (csr_WE),
      .addr      (addr),
      .wd        (wd),
      .pc        (pc),
      .rd        (rd),
      .mepc      (mepc),
      .mtvec     (mtvec),
      .mie       (mie),
      .INTR      (INTR)
   );

   always #5 clk = ~clk;

   // advance one rising edge; inputs change and outputs are sampled 1ns after it
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
      csr_WE = 1'b1; addr = a; wd = d;
      step();
      csr_WE = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      step(2);
      addr = 12'h300; #1;
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_mstatus: got %h expected %h", rd, 32'h0); end
      addr = 12'h305; #1;
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_rd_mtvec: got %h expected %h", rd, 32'h0); end
      addr = 12'h341; #1;
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_rd_mepc: got %h expected %h", rd, 32'h0); end
      addr = 12'h342; #1;
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_rd_mcause: got %h expected %h", rd, 32'h0); end
      checks++; if ({INTR, mie} !== 2'b00) begin errors++; $display("FAIL reset_intr_mie: got %b expected %b", {INTR, mie}, 2'b00); end
      checks++; if ({mepc, mtvec} !== 64'h0) begin errors++; $display("FAIL reset_mepc_mtvec: got %h expected %h", {mepc, mtvec}, 64'h0); end
      RST = 1'b0;
      step();
   endtask

   task automatic test_csr_write();
      csr_write(12'h305, 32'h0000_1003);
      addr = 12'h305; #1;
      checks++; if (mtvec !== 32'h0000_1000) begin errors++; $display("FAIL mtvec_wr: got %h expected %h", mtvec, 32'h0000_1000); end
      checks++; if (rd !== 32'h0000_1000) begin errors++; $display("FAIL mtvec_rd: got %h expected %h", rd, 32'h0000_1000); end
      csr_write(12'h300, 32'hFFFF_FFFF);
      addr = 12'h300; #1;
      checks++; if (rd !== 32'h0000_0088) begin errors++; $display("FAIL mstatus_wr: got %h expected %h", rd, 32'h0000_0088); end
      checks++; if (mie !== 1'b1) begin errors++; $display("FAIL mstatus_mie: got %b expected %b", mie, 1'b1); end
      csr_write(12'h341, 32'h1234_5677);
      checks++; if (mepc !== 32'h1234_5674) begin errors++; $display("FAIL mepc_wr: got %h expected %h", mepc, 32'h1234_5674); end
      csr_write(12'h123, 32'hDEAD_BEEF);
      addr = 12'h123; #1;
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_rd: got %h expected %h", rd, 32'h0); end
      checks++; if ({mtvec, mepc} !== {32'h0000_1000, 32'h1234_5674}) begin errors++; $display("FAIL unmapped_wr: got %h expected %h", {mtvec, mepc}, {32'h0000_1000, 32'h1234_5674}); end
   endtask

   task automatic test_interrupt();
      intr_async = 1'b1;           // high before edge k
      step();                      // edge k
      checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL intr_lat_k: got %b expected %b", INTR, 1'b0); end
      step();                      // edge k+1
      checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL intr_lat_k1: got %b expected %b", INTR, 1'b0); end
      step();                      // edge k+2
      checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL intr_lat_k2: got %b expected %b", INTR, 1'b1); end
      int_taken = 1'b1; pc = 32'h0000_0107;
      step();
      int_taken = 1'b0;
      addr = 12'h300; #1;
      checks++; if (mepc !== 32'h0000_0104) begin errors++; $display("FAIL take_mepc: got %h expected %h", mepc, 32'h0000_0104); end
      checks++; if (rd !== 32'h0000_0080) begin errors++; $display("FAIL take_mstatus: got %h expected %h", rd, 32'h0000_0080); end
      checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL take_intr: got %b expected %b", INTR, 1'b0); end
   endtask

   task automatic test_mret();
      mret_exec = 1'b1;
      step();
      mret_exec = 1'b0;
      addr = 12'h300; #1;
      checks++; if (rd !== 32'h0000_0088) begin errors++; $display("FAIL mret_mstatus: got %h expected %h", rd, 32'h0000_0088); end
      mret_exec = 1'b1; csr_WE = 1'b1; addr = 12'h300; wd = 32'h0;
      step();
      mret_exec = 1'b0; csr_WE = 1'b0;
      #1;
      checks++; if (rd !== 32'h0000_0088) begin errors++; $display("FAIL mret_over_we: got %h expected %h", rd, 32'h0000_0088); end
   endtask

   task automatic test_priority();
      // int_taken beats a same-cycle mtvec write, which is dropped entirely
      int_taken = 1'b1; csr_WE = 1'b1; addr = 12'h305; wd = 32'h0000_2000; pc = 32'h0000_0200;
      step();
      int_taken = 1'b0; csr_WE = 1'b0;
      checks++; if (mtvec !== 32'h0000_1000) begin errors++; $display("FAIL take_over_we_mtvec: got %h expected %h", mtvec, 32'h0000_1000); end
      checks++; if (mepc !== 32'h0000_0200) begin errors++; $display("FAIL take_over_we_mepc: got %h expected %h", mepc, 32'h0000_0200); end
   endtask

   task automatic test_masked();
      intr_async = 1'b0;
      step(4);
      csr_write(12'h300, 32'h0);
      intr_async = 1'b1;
      step(4);
      checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL masked_intr: got %b expected %b", INTR, 1'b0); end
      csr_write(12'h300, 32'h0000_0008);
      checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL unmask_intr: got %b expected %b", INTR, 1'b1); end
      // new edge arrives exactly as the old request is taken
      intr_async = 1'b0;
      step(4);
      intr_async = 1'b1;
      step(2);                     // edges k, k+1: edge detector now high
      int_taken = 1'b1; pc = 32'h0000_0300;
      step();
      int_taken = 1'b0;
      mret_exec = 1'b1;
      step();
      mret_exec = 1'b0;
      checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL edge_with_take: got %b expected %b", INTR, 1'b1); end
      // take it again with no edge: level still high must not re-request
      int_taken = 1'b1;
      step();
      int_taken = 1'b0;
      mret_exec = 1'b1;
      step();
      mret_exec = 1'b0;
      step(3);
      checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL level_one_req: got %b expected %b", INTR, 1'b0); end
   endtask

   task automatic test_mcause();
`ifdef CSR_MCAUSE_EN
      int_taken = 1'b1;
      step();
      int_taken = 1'b0;
      addr = 12'h342; #1;
      checks++; if (rd !== 32'h8000_000B) begin errors++; $display("FAIL mcause_take: got %h expected %h", rd, 32'h8000_000B); end
      csr_write(12'h342, 32'h0000_1234);
      addr = 12'h342; #1;
      checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL mcause_wr: got %h expected %h", rd, 32'h0000_1234); end
`else
      csr_write(12'h342, 32'h0000_1234);
      addr = 12'h342; #1;
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mcause_absent_wr: got %h expected %h", rd, 32'h0); end
      int_taken = 1'b1;
      step();
      int_taken = 1'b0;
      #1;
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mcause_absent_take: got %h expected %h", rd, 32'h0); end
`endif
   endtask

   task automatic test_reset_mid();
      csr_write(12'h300, 32'h0);
      intr_async = 1'b0;
      step(4);
      intr_async = 1'b1;
      step(4);                     // request pending, masked
      RST = 1'b1; intr_async = 1'b0;
      step();
      RST = 1'b0;
      addr = 12'h305; #1;
      checks++; if ({rd, mepc} !== 64'h0) begin errors++; $display("FAIL rst_mid_regs: got %h expected %h", {rd, mepc}, 64'h0); end
      csr_write(12'h300, 32'h0000_0008);
      checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL rst_mid_pending: got %b expected %b", INTR, 1'b0); end
   endtask

   initial begin
      test_reset();
      test_csr_write();
      test_interrupt();
      test_mret();
      test_priority();
      test_masked();
      test_mcause();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
